// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state encoding for the BCD-to-binary converter
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - per-digit correction cell: subtract 3 when the digit is 8 or more
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din - BCD_ADJ_SUB : din;

endmodule

// File: rtl/bcd_to_binary_converter.sv
// rtl/bcd_to_binary_converter.sv - iterative reverse double-dabble BCD to binary converter
module bcd_to_binary_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err,
  output logic                        busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  conv_state_e state_q, state_d;

  logic [BCD_W-1:0]  bcd_sr;
  logic [BIN_W-1:0]  bin_sr;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  bcd_shift;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BIN_W-1:0]  bin_shift;
  logic [DIGITS-1:0] digit_bad;
  logic              any_bad;
  logic              last_step;

  // One step moves the low BCD bit into the top of the binary register.
  assign bcd_shift = bcd_sr >> 1;
  assign bin_shift = {bcd_sr[0], bin_sr[BIN_W-1:1]};
  assign last_step = (cnt == CNT_LAST);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .din  (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
    assign digit_bad[g] = (bcd_in[g*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT);
  end

  assign any_bad = |digit_bad;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = any_bad ? DONE : CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bcd_sr  <= bcd_in;
            bin_sr  <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= any_bad;
          end
        end
        CONV: begin
          bcd_sr <= bcd_adj;
          bin_sr <= bin_shift;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            bin_out <= bin_shift;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// tb/tb_bcd_to_binary_converter.sv - scoreboard bench for the BCD-to-binary converter
module tb_bcd_to_binary_converter;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [11:0]       bcd_in;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  bin_out;
  logic              out_valid;
  logic              out_ready;
  logic              err;
  logic              busy;

  bcd_to_binary_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    bit err;
    int lat;
    int acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   first_cyc = 0;
  bit   prev_ov = 1'b0;
  int   codes[1000];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [11:0] to_bcd(input int d);
    logic [11:0] r;
    r[11:8] = 4'((d / 100) % 10);
    r[7:4]  = 4'((d / 10) % 10);
    r[3:0]  = 4'(d % 10);
    return r;
  endfunction

  // Drives one operand; the accept edge index is recorded for latency.
  task automatic send(input logic [11:0] v, input int bin, input bit e);
    int   waited;
    exp_t x;
    waited = 0;
    @(negedge clk);
    bcd_in   = v;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    check("accept_no_ov", 32'(out_valid), 32'd0);
    x.bin = bin;
    x.err = e;
    x.lat = e ? 0 : BIN_W;
    x.acc = cyc + 1;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb_q.size() > 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        first_cyc = cyc;
        if (!err) check("bcd_sr_zero", 32'(dut.bcd_sr), 32'd0);
      end
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_x = sb_q.pop_front();
          check("bin_out", 32'(bin_out), 32'(mon_x.bin));
          check("err", 32'(err), 32'(mon_x.err));
          check("latency", 32'(first_cyc - mon_x.acc), 32'(mon_x.lat));
          check("hs_in_ready", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  initial begin
    int waited;
    int j;
    int t;
    rst       = 1'b1;
    bcd_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    send(12'h999, 999, 1'b0);
    drain();
    check("t1_in_ready_after", 32'(in_ready), 32'd1);

    send(12'h000, 0, 1'b0);
    send(12'h255, 255, 1'b0);
    drain();

    send(12'h1A3, 0, 1'b1);
    drain();

    out_ready = 1'b0;
    send(12'h512, 512, 1'b0);
    waited = 0;
    while (!out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("stall_ov_rise", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ov", 32'(out_valid), 32'd1);
      check("stall_bin", 32'(bin_out), 32'd512);
      in_valid = k[0];
      bcd_in   = 12'h777;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) begin
      @(negedge clk);
      check("post_stall_idle_ov", 32'(out_valid), 32'd0);
      check("post_stall_idle_busy", 32'(busy), 32'd0);
    end

    send(12'h640, 640, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_bin_out", 32'(bin_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    send(12'h031, 31, 1'b0);
    drain();

    for (int i = 0; i < 1000; i++) codes[i] = i;
    for (int i = 999; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = codes[i];
      codes[i] = codes[j];
      codes[j] = t;
    end
    for (int i = 0; i < 1000; i++) send(to_bcd(codes[i]), codes[i], 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
